// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-lane ALU arbiter: FSM states, widths and
// the bit positions of the one-hot ALU operation select.
package alu_arb_pkg;

    localparam int DATA_W = 16;
    localparam int SIG_W  = 13;
    localparam int IMM_W  = 5;
    localparam int CNT_W  = 3;   // holds ALU_LAT up to 4

    // Bit positions inside alusignals (bit 0 = add).
    localparam int SIG_ADD = 0;
    localparam int SIG_LD  = 1;
    localparam int SIG_ST  = 2;
    localparam int SIG_SUB = 3;
    localparam int SIG_MUL = 4;
    localparam int SIG_CMP = 5;
    localparam int SIG_MOV = 6;
    localparam int SIG_OR  = 7;
    localparam int SIG_AND = 8;
    localparam int SIG_NOT = 9;
    localparam int SIG_LSL = 10;
    localparam int SIG_LSR = 11;
    localparam int SIG_XOR = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way round-robin grant. On a tie the lane that did not win the last
// accepted request is granted; the history bit changes only on acceptance.
module alu_arb_rr (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_accept,
    output logic o_gnt0,
    output logic o_gnt1
);

    // 1 = lane 1 won last, so lane 0 wins the first tie after reset.
    logic r_last_grant;

    // Grant a lone requester outright; on a tie favour the other lane.
    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_req0 && i_req1) begin
            o_gnt0 = r_last_grant;
            o_gnt1 = ~r_last_grant;
        end else begin
            o_gnt0 = i_req0;
            o_gnt1 = i_req1;
        end
    end

    // Record the winner only when its request is actually taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (i_accept) begin
            r_last_grant <= o_gnt1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-lane arbiter in front of one shared, registered ALU. One operation is
// in flight at a time: IDLE (grant) -> EXEC (drive ALU for ALU_LAT+1 cycles)
// -> RESP (hold result until the owner accepts it).
// Build option: define ALU_ARB_FIXED_PRIO_EN to make lane 0 win every tie
// instead of round-robin.
// ALU_LAT legal range is 1..4.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [SIG_W-1:0]  req0_alusignals,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [IMM_W-1:0]  req0_immx,
    input  logic              req0_isimm,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [SIG_W-1:0]  req1_alusignals,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [IMM_W-1:0]  req1_immx,
    input  logic              req1_isimm,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,

    output logic [SIG_W-1:0]  alu_signals,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [IMM_W-1:0]  alu_immx,
    output logic              alu_isimm,
    input  logic [DATA_W-1:0] alu_result
);

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_owner;
    logic [SIG_W-1:0]    r_sig;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    logic [IMM_W-1:0]    r_immx;
    logic                r_isimm;
    logic [DATA_W-1:0]   r_result;

    logic w_idle;
    logic w_exec;
    logic w_resp;
    logic w_gnt0;
    logic w_gnt1;
    logic w_hs0;
    logic w_hs1;
    logic w_hs;
    logic w_exec_done;
    logic w_rsp_accept;

    assign w_idle = (r_state == ST_IDLE);
    assign w_exec = (r_state == ST_EXEC);
    assign w_resp = (r_state == ST_RESP);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Lane 0 always wins; no grant history is kept.
    assign w_gnt0 = req0_valid;
    assign w_gnt1 = req1_valid & ~req0_valid;
`else
    alu_arb_rr u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req0   (req0_valid),
        .i_req1   (req1_valid),
        .i_accept (w_hs),
        .o_gnt0   (w_gnt0),
        .o_gnt1   (w_gnt1)
    );
`endif

    // Grants are only visible while IDLE, so the loser and busy states see 0.
    assign req0_ready = w_idle & w_gnt0;
    assign req1_ready = w_idle & w_gnt1;

    assign w_hs0        = req0_valid & req0_ready;
    assign w_hs1        = req1_valid & req1_ready;
    assign w_hs         = w_hs0 | w_hs1;
    assign w_exec_done  = w_exec && (r_cnt == '0);
    assign w_rsp_accept = w_resp && (r_owner ? rsp1_ready : rsp0_ready);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: accept -> run the ALU -> wait for the owner to take the result.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_hs)         w_next_state = ST_EXEC;
            ST_EXEC: if (w_exec_done)  w_next_state = ST_RESP;
            ST_RESP: if (w_rsp_accept) w_next_state = ST_IDLE;
            default:                   w_next_state = ST_IDLE;
        endcase
    end

    // Latch the winning request, count down the ALU latency, capture the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_owner  <= 1'b0;
            r_sig    <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_immx   <= '0;
            r_isimm  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_hs) begin
                r_owner <= w_hs1;
                r_sig   <= w_hs1 ? req1_alusignals : req0_alusignals;
                r_op1   <= w_hs1 ? req1_op1        : req0_op1;
                r_op2   <= w_hs1 ? req1_op2        : req0_op2;
                r_immx  <= w_hs1 ? req1_immx       : req0_immx;
                r_isimm <= w_hs1 ? req1_isimm      : req0_isimm;
                r_cnt   <= CNT_W'(ALU_LAT);
            end else if (w_exec && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_exec_done) begin
                r_result <= alu_result;
            end
        end
    end

    // The ALU sees an all-zero op outside EXEC so it cannot update flags.
    assign alu_signals = w_exec ? r_sig   : '0;
    assign alu_op1     = w_exec ? r_op1   : '0;
    assign alu_op2     = w_exec ? r_op2   : '0;
    assign alu_immx    = w_exec ? r_immx  : '0;
    assign alu_isimm   = w_exec ? r_isimm : 1'b0;

    assign rsp0_valid  = w_resp & ~r_owner;
    assign rsp1_valid  = w_resp &  r_owner;
    assign rsp_result  = w_resp ? r_result : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: instance A (ALU_LAT=1) takes a vector
// table plus tie, hold and reset sequences; instance B (ALU_LAT=3) takes the
// long-latency immediate case. A small registered ALU stand-in feeds each.
module tb_alu_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0]       a_rv, a_rdy, a_rspv, a_rsprdy, a_risimm;
    logic [1:0][12:0] a_rsig;
    logic [1:0][15:0] a_rop1, a_rop2;
    logic [1:0][4:0]  a_rimm;
    logic [15:0]      a_rsp_result, a_alu_op1, a_alu_op2, a_alu_result;
    logic [12:0]      a_alu_sig;
    logic [4:0]       a_alu_immx;
    logic             a_alu_isimm;

    logic [1:0]       b_rv, b_rdy, b_rspv, b_rsprdy, b_risimm;
    logic [1:0][12:0] b_rsig;
    logic [1:0][15:0] b_rop1, b_rop2;
    logic [1:0][4:0]  b_rimm;
    logic [15:0]      b_rsp_result, b_alu_op1, b_alu_op2, b_alu_result;
    logic [12:0]      b_alu_sig;
    logic [4:0]       b_alu_immx;
    logic             b_alu_isimm;
    logic [15:0]      b_q0, b_q1;

    alu_arbiter #(.ALU_LAT(LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(a_rv[0]), .req0_ready(a_rdy[0]), .req0_alusignals(a_rsig[0]),
        .req0_op1(a_rop1[0]), .req0_op2(a_rop2[0]), .req0_immx(a_rimm[0]), .req0_isimm(a_risimm[0]),
        .req1_valid(a_rv[1]), .req1_ready(a_rdy[1]), .req1_alusignals(a_rsig[1]),
        .req1_op1(a_rop1[1]), .req1_op2(a_rop2[1]), .req1_immx(a_rimm[1]), .req1_isimm(a_risimm[1]),
        .rsp0_valid(a_rspv[0]), .rsp0_ready(a_rsprdy[0]),
        .rsp1_valid(a_rspv[1]), .rsp1_ready(a_rsprdy[1]),
        .rsp_result(a_rsp_result),
        .alu_signals(a_alu_sig), .alu_op1(a_alu_op1), .alu_op2(a_alu_op2),
        .alu_immx(a_alu_immx), .alu_isimm(a_alu_isimm), .alu_result(a_alu_result)
    );

    alu_arbiter #(.ALU_LAT(LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_rv[0]), .req0_ready(b_rdy[0]), .req0_alusignals(b_rsig[0]),
        .req0_op1(b_rop1[0]), .req0_op2(b_rop2[0]), .req0_immx(b_rimm[0]), .req0_isimm(b_risimm[0]),
        .req1_valid(b_rv[1]), .req1_ready(b_rdy[1]), .req1_alusignals(b_rsig[1]),
        .req1_op1(b_rop1[1]), .req1_op2(b_rop2[1]), .req1_immx(b_rimm[1]), .req1_isimm(b_risimm[1]),
        .rsp0_valid(b_rspv[0]), .rsp0_ready(b_rsprdy[0]),
        .rsp1_valid(b_rspv[1]), .rsp1_ready(b_rsprdy[1]),
        .rsp_result(b_rsp_result),
        .alu_signals(b_alu_sig), .alu_op1(b_alu_op1), .alu_op2(b_alu_op2),
        .alu_immx(b_alu_immx), .alu_isimm(b_alu_isimm), .alu_result(b_alu_result)
    );

    // Stand-in for the shared ALU; unlisted select patterns yield 16'hDEAD.
    function automatic logic [15:0] alu_f(input logic [12:0] s, input logic [15:0] a,
                                          input logic [15:0] op2, input logic [4:0] imm,
                                          input logic isimm);
        logic [15:0] b;
        b = isimm ? {11'd0, imm} : op2;
        case (s)
            13'h0000: alu_f = 16'h0000;
            13'h0001: alu_f = a + b;
            13'h0002: alu_f = a + b;
            13'h0004: alu_f = a + b;
            13'h0008: alu_f = a - b;
            13'h0010: alu_f = a * b;
            13'h0020: alu_f = a - b;
            13'h0040: alu_f = b;
            13'h0080: alu_f = a | b;
            13'h0100: alu_f = a & b;
            13'h0200: alu_f = ~a;
            13'h0400: alu_f = a << b;
            13'h0800: alu_f = a >> b;
            13'h1000: alu_f = a ^ b;
            default:  alu_f = 16'hDEAD;
        endcase
    endfunction

    always @(posedge clk) a_alu_result <= alu_f(a_alu_sig, a_alu_op1, a_alu_op2, a_alu_immx, a_alu_isimm);

    always @(posedge clk) begin
        b_q0         <= alu_f(b_alu_sig, b_alu_op1, b_alu_op2, b_alu_immx, b_alu_isimm);
        b_q1         <= b_q0;
        b_alu_result <= b_q1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request on a lane, check it is granted, take the handshake.
    task automatic issue_a(input int lane, input logic [12:0] sig, input logic [15:0] op1,
                           input logic [15:0] op2, input logic [4:0] imm, input logic isimm,
                           input string tag);
        a_rsig[lane] = sig; a_rop1[lane] = op1; a_rop2[lane] = op2;
        a_rimm[lane] = imm; a_risimm[lane] = isimm; a_rv[lane] = 1'b1;
        #1;
        chk({tag, "_grant"}, 32'(a_rdy), 32'(1) << lane);
        tick();
        a_rv[lane] = 1'b0;
        chk({tag, "_alu_op2"}, 32'(a_alu_op2), 32'(op2));
        chk({tag, "_alu_immx"}, 32'(a_alu_immx), 32'(imm));
        chk({tag, "_alu_isimm"}, 32'(a_alu_isimm), 32'(isimm));
    endtask

    // Follow an accepted op on instance A through EXEC and RESP.
    task automatic serve_a(input int lane, input logic [12:0] sig, input logic [15:0] op1,
                           input logic [15:0] exp, input int hold, input string tag);
        int n;
        n = 0;
        while (a_rspv[lane] !== 1'b1 && n < 10) begin
            chk({tag, "_rdy_busy"}, 32'(a_rdy), 32'd0);
            chk({tag, "_alu_sig"}, 32'(a_alu_sig), 32'(sig));
            chk({tag, "_alu_op1"}, 32'(a_alu_op1), 32'(op1));
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(LAT_A + 1));
        chk({tag, "_rspv"}, 32'(a_rspv), 32'(1) << lane);
        chk({tag, "_result"}, 32'(a_rsp_result), 32'(exp));
        chk({tag, "_alu_quiet"}, 32'(a_alu_sig), 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_rspv"}, 32'(a_rspv), 32'(1) << lane);
            chk({tag, "_hold_result"}, 32'(a_rsp_result), 32'(exp));
            chk({tag, "_hold_rdy"}, 32'(a_rdy), 32'd0);
        end
        a_rsprdy[lane] = 1'b1;
        tick();
        a_rsprdy[lane] = 1'b0;
        chk({tag, "_rspv_done"}, 32'(a_rspv), 32'd0);
        chk({tag, "_rsp_zero"}, 32'(a_rsp_result), 32'd0);
    endtask

    typedef struct {
        int          lane;
        logic [12:0] sig;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [4:0]  immx;
        logic        isimm;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int w;
        int n;

        vecs[0] = '{0, 13'h0001, 16'd3,      16'd4,      5'd0, 1'b0, 16'd7};
        vecs[1] = '{1, 13'h0008, 16'd100,    16'd58,     5'd0, 1'b0, 16'd42};
        vecs[2] = '{0, 13'h0010, 16'd300,    16'd300,    5'd0, 1'b0, 16'h5F90};
        vecs[3] = '{1, 13'h1000, 16'hF0F0,   16'h0FF0,   5'd0, 1'b0, 16'hFF00};
        vecs[4] = '{0, 13'h0400, 16'h0123,   16'h7777,   5'd4, 1'b1, 16'h1230};
        vecs[5] = '{1, 13'h0001, 16'hFFFF,   16'd2,      5'd0, 1'b0, 16'h0001};
        vecs[6] = '{0, 13'h0181, 16'h0005,   16'h0006,   5'd0, 1'b0, 16'hDEAD};

        rst_n = 1'b0;
        a_rv = '0; a_rsprdy = '0; a_rsig = '0; a_rop1 = '0; a_rop2 = '0; a_rimm = '0; a_risimm = '0;
        b_rv = '0; b_rsprdy = '0; b_rsig = '0; b_rop1 = '0; b_rop2 = '0; b_rimm = '0; b_risimm = '0;
        repeat (3) tick();

        chk("reset_rdy", 32'(a_rdy), 32'd0);
        chk("reset_rspv", 32'(a_rspv), 32'd0);
        chk("reset_rsp_result", 32'(a_rsp_result), 32'd0);
        chk("reset_alu_sig", 32'(a_alu_sig), 32'd0);
        chk("reset_alu_op1", 32'(a_alu_op1), 32'd0);
        rst_n = 1'b1;
        tick();

        // Both lanes continuously valid: alternation, or lane 0 every time.
        a_rsig[0] = 13'h0001; a_rop1[0] = 16'd1; a_rop2[0] = 16'd1;
        a_rsig[1] = 13'h0001; a_rop1[1] = 16'd2; a_rop2[1] = 16'd2;
        a_rv = 2'b11;
        for (int k = 0; k < 4; k++) begin
            w = FIXED ? 0 : (k % 2);
            #1;
            chk($sformatf("tie%0d_grant", k), 32'(a_rdy), 32'(1) << w);
            tick();
            serve_a(w, 13'h0001, (w == 1) ? 16'd2 : 16'd1, (w == 1) ? 16'd4 : 16'd2, 0,
                    $sformatf("tie%0d", k));
        end
        a_rv = 2'b00;

        // Owner stalls its response for 5 cycles while lane 0 waits.
        issue_a(1, 13'h0008, 16'd9, 16'd4, 5'd0, 1'b0, "hold");
        a_rsig[0] = 13'h0001; a_rop1[0] = 16'd1; a_rop2[0] = 16'd1; a_rv[0] = 1'b1;
        serve_a(1, 13'h0008, 16'd9, 16'd5, 5, "hold");
        #1;
        chk("after_hold_grant", 32'(a_rdy), 32'd1);
        tick();
        a_rv[0] = 1'b0;
        serve_a(0, 13'h0001, 16'd1, 16'd2, 0, "after_hold");

        // Reset while a mul is executing: it must vanish without a response.
        issue_a(0, 13'h0010, 16'd5, 16'd6, 5'd0, 1'b0, "rstexec");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("rstexec_no_rspv", 32'(a_rspv), 32'd0);
            chk("rstexec_alu_quiet", 32'(a_alu_sig), 32'd0);
            tick();
        end
        issue_a(1, 13'h0001, 16'd7, 16'd8, 5'd0, 1'b0, "post_rst");
        serve_a(1, 13'h0001, 16'd7, 16'd15, 0, "post_rst");

        // Single-lane vector table.
        for (int i = 0; i < 7; i++) begin
            issue_a(vecs[i].lane, vecs[i].sig, vecs[i].op1, vecs[i].op2, vecs[i].immx,
                    vecs[i].isimm, $sformatf("vec%0d", i));
            serve_a(vecs[i].lane, vecs[i].sig, vecs[i].op1, vecs[i].exp, 0,
                    $sformatf("vec%0d", i));
        end

        // Instance B: lane 1 sub with immediate, ALU_LAT=3.
        b_rsig[1] = 13'h0008; b_rop1[1] = 16'd10; b_rop2[1] = 16'h1234;
        b_rimm[1] = 5'd2; b_risimm[1] = 1'b1; b_rv[1] = 1'b1;
        #1;
        chk("lat3_grant", 32'(b_rdy), 32'd2);
        tick();
        b_rv[1] = 1'b0;
        n = 0;
        while (b_rspv[1] !== 1'b1 && n < 10) begin
            chk("lat3_rdy_busy", 32'(b_rdy), 32'd0);
            chk("lat3_alu_isimm", 32'(b_alu_isimm), 32'd1);
            tick();
            n++;
        end
        chk("lat3_latency", 32'(n), 32'(LAT_B + 1));
        chk("lat3_rspv", 32'(b_rspv), 32'd2);
        chk("lat3_result", 32'(b_rsp_result), 32'd8);
        b_rsprdy[1] = 1'b1;
        tick();
        b_rsprdy[1] = 1'b0;
        chk("lat3_rspv_done", 32'(b_rspv), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
